// File: rtl/alarm_siren_if.sv
// ============================================================================
// Module   : alarm_siren_if
// Brief    : Request/annunciator bundle between the alarm decoder, the
//            alarm_siren block and the annunciator outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_siren_if;
  logic alarmEnable;
  logic silence_btn;
  logic test_btn;
  logic siren;
  logic strobe;
  logic alarm_latched;
  logic silenced;
  logic test_active;

  // master: request/button source; slave: the alarm_siren block
  modport master (
    output alarmEnable,
    output silence_btn,
    output test_btn,
    input  siren,
    input  strobe,
    input  alarm_latched,
    input  silenced,
    input  test_active
  );

  modport slave (
    input  alarmEnable,
    input  silence_btn,
    input  test_btn,
    output siren,
    output strobe,
    output alarm_latched,
    output silenced,
    output test_active
  );
endinterface

`default_nettype wire

// File: rtl/alarm_siren.sv
// ============================================================================
// Module   : alarm_siren
// Brief    : Confirms a sustained alarmEnable request, latches the alarm and
//            drives siren/strobe with timed silence and self-test.
//            Strobe logic is present only when ALARM_STROBE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_siren #(
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned TONE_HALF      = 8,
  parameter int unsigned STROBE_PERIOD  = 16,
  parameter int unsigned SILENCE_CYCLES = 64,
  parameter int unsigned TEST_CYCLES    = 32
) (
  input  logic         clk,
  input  logic         rst,
  alarm_siren_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONFIRM  = 3'd1,
    ST_ALARM    = 3'd2,
    ST_SILENCED = 3'd3,
    ST_TEST     = 3'd4
  } state_t;

  localparam logic [15:0] c_confirm_last = 16'(CONFIRM_CYCLES - 1);
  localparam logic [15:0] c_tone_last    = 16'(TONE_HALF - 1);
  localparam logic [15:0] c_silence_load = 16'(SILENCE_CYCLES);
  localparam logic [15:0] c_test_load    = 16'(TEST_CYCLES);

  if (CONFIRM_CYCLES < 1 || CONFIRM_CYCLES > 65535) begin : g_chk_confirm
    $error("alarm_siren: CONFIRM_CYCLES out of range");
  end
  if (TONE_HALF < 1 || TONE_HALF > 65535) begin : g_chk_tone
    $error("alarm_siren: TONE_HALF out of range");
  end
  if (STROBE_PERIOD < 2 || STROBE_PERIOD > 65535) begin : g_chk_strobe
    $error("alarm_siren: STROBE_PERIOD out of range");
  end
  if (SILENCE_CYCLES < 1 || SILENCE_CYCLES > 65535) begin : g_chk_silence
    $error("alarm_siren: SILENCE_CYCLES out of range");
  end
  if (TEST_CYCLES < 1 || TEST_CYCLES > 65535) begin : g_chk_test
    $error("alarm_siren: TEST_CYCLES out of range");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] r_sil;
  logic [15:0] w_sil_nxt;
  logic [15:0] r_test;
  logic [15:0] w_test_nxt;
  logic [15:0] r_tone;
  logic [15:0] w_tone_nxt;
  logic        r_siren;
  logic        w_siren_nxt;
  logic        r_alarm_latched;
  logic        r_silenced;
  logic        r_test_active;
  logic        w_latched_cur;
  logic        w_latched_nxt;
  logic        w_tone_run_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control counters
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sil_nxt   = r_sil;
    w_test_nxt  = r_test;
    case (r_state)
      ST_IDLE: begin
        if (bus.alarmEnable) begin
          if (CONFIRM_CYCLES == 1) begin
            w_state_nxt = ST_ALARM;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_CONFIRM;
            w_cnt_nxt   = 16'd1;
          end
        end else if (bus.test_btn) begin
          w_state_nxt = ST_TEST;
          w_test_nxt  = c_test_load;
        end
      end
      ST_CONFIRM: begin
        if (!bus.alarmEnable) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_confirm_last) begin
          w_state_nxt = ST_ALARM;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      ST_ALARM: begin
        if (bus.silence_btn) begin
          w_state_nxt = ST_SILENCED;
          w_sil_nxt   = c_silence_load;
        end
      end
      ST_SILENCED: begin
        // Timer only counts down; further presses never reload it.
        if (r_sil == 16'd1) begin
          w_sil_nxt   = '0;
          w_state_nxt = bus.alarmEnable ? ST_ALARM : ST_IDLE;
        end else begin
          w_sil_nxt   = r_sil - 16'd1;
        end
      end
      ST_TEST: begin
        if (bus.alarmEnable) begin
          w_test_nxt = '0;
          if (CONFIRM_CYCLES == 1) begin
            w_state_nxt = ST_ALARM;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_CONFIRM;
            w_cnt_nxt   = 16'd1;
          end
        end else if (r_test == 16'd1) begin
          w_state_nxt = ST_IDLE;
          w_test_nxt  = '0;
        end else begin
          w_test_nxt  = r_test - 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_sil_nxt   = '0;
        w_test_nxt  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Siren tone generator
  // --------------------------------------------------------------------------
  assign w_latched_cur  = (r_state == ST_ALARM) || (r_state == ST_SILENCED);
  assign w_latched_nxt  = (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_SILENCED);
  assign w_tone_run_nxt = (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_TEST);

  always_comb begin
    w_tone_nxt  = '0;
    w_siren_nxt = 1'b0;
    if (w_tone_run_nxt) begin
      // Any state change into ALARM/TEST restarts the tone high.
      if (w_state_nxt != r_state) begin
        w_tone_nxt  = '0;
        w_siren_nxt = 1'b1;
      end else if (r_tone == c_tone_last) begin
        w_tone_nxt  = '0;
        w_siren_nxt = ~r_siren;
      end else begin
        w_tone_nxt  = r_tone + 16'd1;
        w_siren_nxt = r_siren;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_sil           <= '0;
      r_test          <= '0;
      r_tone          <= '0;
      r_siren         <= 1'b0;
      r_alarm_latched <= 1'b0;
      r_silenced      <= 1'b0;
      r_test_active   <= 1'b0;
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_sil           <= w_sil_nxt;
      r_test          <= w_test_nxt;
      r_tone          <= w_tone_nxt;
      r_siren         <= w_siren_nxt;
      r_alarm_latched <= w_latched_nxt;
      r_silenced      <= (w_state_nxt == ST_SILENCED);
      r_test_active   <= (w_state_nxt == ST_TEST);
    end
  end

  assign bus.siren         = r_siren;
  assign bus.alarm_latched = r_alarm_latched;
  assign bus.silenced      = r_silenced;
  assign bus.test_active   = r_test_active;

  // --------------------------------------------------------------------------
  // Strobe: free-runs across ALARM<->SILENCED, restarts on a fresh latch
  // --------------------------------------------------------------------------
`ifdef ALARM_STROBE_EN
  localparam logic [15:0] c_strobe_last = 16'(STROBE_PERIOD - 1);

  logic [15:0] r_strb;
  logic [15:0] w_strb_nxt;
  logic        r_strobe;
  logic        w_strobe_nxt;

  always_comb begin
    w_strb_nxt   = '0;
    w_strobe_nxt = 1'b0;
    if (w_latched_nxt) begin
      if (w_latched_cur) begin
        w_strb_nxt = (r_strb == c_strobe_last) ? 16'd0 : (r_strb + 16'd1);
      end
      w_strobe_nxt = (w_strb_nxt == 16'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_strb   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strb   <= w_strb_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign bus.strobe = r_strobe;
`else
  assign bus.strobe = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_siren.sv
// ============================================================================
// Module   : tb_alarm_siren
// Brief    : Scoreboard bench for alarm_siren; strobe expectations follow
//            ALARM_STROBE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alarm_siren;

  localparam int CONFIRM = 4;
  localparam int TH      = 8;
  localparam int SP      = 16;
  localparam int SIL     = 64;
  localparam int TC      = 32;
`ifdef ALARM_STROBE_EN
  localparam bit STROBE_ON = 1'b1;
`else
  localparam bit STROBE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] obs;
  logic [4:0] e;

  alarm_siren_if bus_if ();

  alarm_siren #(
    .CONFIRM_CYCLES (CONFIRM),
    .TONE_HALF      (TH),
    .STROBE_PERIOD  (SP),
    .SILENCE_CYCLES (SIL),
    .TEST_CYCLES    (TC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  // {alarm_latched, silenced, test_active, siren, strobe}
  assign obs = {bus_if.alarm_latched, bus_if.silenced, bus_if.test_active,
                bus_if.siren, bus_if.strobe};

  function automatic logic tone(input int a);
    return ((a / TH) % 2) == 0;
  endfunction

  function automatic logic strb(input int a);
    return STROBE_ON && ((a % SP) == 0);
  endfunction

  function automatic logic [4:0] alarm_v(input int a_tone, input int a_strb);
    return {1'b1, 1'b0, 1'b0, tone(a_tone), strb(a_strb)};
  endfunction

  function automatic logic [4:0] silenced_v(input int a_strb);
    return {1'b1, 1'b1, 1'b0, 1'b0, strb(a_strb)};
  endfunction

  task automatic drive(input logic ae, input logic sil, input logic tst);
    bus_if.alarmEnable = ae;
    bus_if.silence_btn = sil;
    bus_if.test_btn    = tst;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 22; t++) begin
      if (t < 2) begin
        rst = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
      end
      exp_q.push_back(5'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_idle t=%0d got=%b exp=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_self_test();
    for (int t = 0; t < TC + 4; t++) begin
      drive(1'b0, 1'b0, t == 0);
      exp_q.push_back(t < TC ? {3'b001, tone(t), 1'b0} : 5'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL self_test t=%0d got=%b exp=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_confirm_filter();
    do_reset();
    for (int t = 0; t < 52; t++) begin
      drive((t < 3) || (t >= 8 && t < 12), 1'b0, 1'b0);
      exp_q.push_back(t < 11 ? 5'b0 : alarm_v(t - 11, t - 11));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL confirm_filter t=%0d got=%b exp=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_silence_burning();
    do_reset();
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, t == 13, 1'b0);
      if (t < 3)             exp_q.push_back(5'b0);
      else if (t < 13)       exp_q.push_back(alarm_v(t - 3, t - 3));
      else if (t < 13 + SIL) exp_q.push_back(silenced_v(t - 3));
      else                   exp_q.push_back(alarm_v(t - 13 - SIL, t - 3));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL silence_burning t=%0d got=%b exp=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_silence_cleared();
    do_reset();
    for (int t = 0; t < 86; t++) begin
      drive(t < 4, (t == 13) || (t == 30) || (t == 50) || (t == 70) || (t == 76), 1'b0);
      if (t < 3)             exp_q.push_back(5'b0);
      else if (t < 13)       exp_q.push_back(alarm_v(t - 3, t - 3));
      else if (t < 13 + SIL) exp_q.push_back(silenced_v(t - 3));
      else                   exp_q.push_back(5'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL silence_cleared t=%0d got=%b exp=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_test_abort();
    do_reset();
    for (int t = 0; t < 30; t++) begin
      drive(t >= 5 && t < 9, 1'b0, t == 0);
      if (t < 5)      exp_q.push_back({3'b001, tone(t), 1'b0});
      else if (t < 8) exp_q.push_back(5'b0);
      else            exp_q.push_back(alarm_v(t - 8, t - 8));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL test_abort t=%0d got=%b exp=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_silence();
    do_reset();
    for (int t = 0; t < 26; t++) begin
      rst = (t == 20);
      drive(t < 4, t == 6, 1'b0);
      if (t < 3)       exp_q.push_back(5'b0);
      else if (t < 6)  exp_q.push_back(alarm_v(t - 3, t - 3));
      else if (t < 20) exp_q.push_back(silenced_v(t - 3));
      else             exp_q.push_back(5'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_silence t=%0d got=%b exp=%b", t, obs, e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    test_reset();
    test_self_test();
    test_confirm_filter();
    test_silence_burning();
    test_silence_cleared();
    test_test_abort();
    test_reset_mid_silence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alarm_siren.md
# alarm_siren

Consumer end of the `alarmEnable` line produced by the fire-alarm decoder. Confirms a sustained `alarmEnable` request, then latches an alarm condition. While latched it drives a square-wave siren and a periodic strobe pulse. It also provides a timed silence function and a self-test mode, and sits between the fire-alarm logic and the annunciator outputs of the home-automation system.

## Interface
- `CONFIRM_CYCLES`, 4: consecutive high samples of `alarmEnable` required to latch; 1 to 65535.
- `TONE_HALF`, 8: siren half-period in cycles; 1 to 65535.
- `STROBE_PERIOD`, 16: strobe repeat period in cycles; 2 to 65535.
- `SILENCE_CYCLES`, 64: silence duration in cycles; 1 to 65535.
- `TEST_CYCLES`, 32: self-test duration in cycles; 1 to 65535.

Ports:
- `clk` input 1: the single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `alarmEnable` input 1: alarm request from the fire-alarm decoder.
- `silence_btn` input 1: level, silence request.
- `test_btn` input 1: level, self-test request.
- `siren` output 1: siren drive, square wave.
- `strobe` output 1: one-cycle strobe pulse.
- `alarm_latched` output 1: high in ALARM or SILENCED.
- `silenced` output 1: high in SILENCED.
- `test_active` output 1: high in TEST.

## Operation
- States: IDLE, CONFIRM, ALARM, SILENCED, TEST. All outputs are registered.
- Reset value of every output is 0. Reset puts the block in IDLE and zeroes all counters. Reset takes priority over all other inputs, including mid-alarm and mid-silence.
- IDLE:
  - `alarmEnable`=1 goes to CONFIRM with `cnt`=1. If `CONFIRM_CYCLES`=1 it goes directly to ALARM.
  - Otherwise `test_btn`=1 goes to TEST.
  - `alarmEnable` has priority over `test_btn`. `silence_btn` is ignored.
- CONFIRM:
  - `alarmEnable`=0 returns to IDLE.
  - If `alarmEnable`=1 and `cnt`=`CONFIRM_CYCLES`-1, go to ALARM. Otherwise increment `cnt`.
  - Both buttons are ignored.
- ALARM:
  - Stays latched even after `alarmEnable` drops.
  - `silence_btn`=1 goes to SILENCED and loads the silence timer with `SILENCE_CYCLES`.
  - `test_btn` is ignored.
- SILENCED:
  - The timer decrements each cycle. When it reaches 0: go to ALARM if `alarmEnable`=1, otherwise go to IDLE (the alarm is cleared).
  - Further `silence_btn` presses do not extend the timer. `test_btn` is ignored.
- TEST:
  - Siren runs exactly as in ALARM. The strobe is off.
  - Exits to IDLE after `TEST_CYCLES` cycles.
  - `alarmEnable`=1 aborts the test into CONFIRM with `cnt`=1, or directly into ALARM if `CONFIRM_CYCLES`=1.
- Siren:
  - The tone counter clears on every entry to ALARM or TEST. `siren` is 1 on the first cycle of the state.
  - `siren` toggles whenever the tone counter reaches `TONE_HALF`-1; the counter then wraps to 0.
  - `siren`=0 in all other states.
- Strobe:
  - Active in ALARM and SILENCED.
  - The strobe counter clears on entry from IDLE or CONFIRM. It is not cleared on ALARM↔SILENCED transitions.
  - `strobe`=1 when the counter is 0. The counter wraps at `STROBE_PERIOD`-1.
- All counters are 16 bits. No counter ever wraps past its parameter limit.

## Timing
- Let `alarmEnable` be high at edges e0…e(N-1), where N=`CONFIRM_CYCLES`. After edge e(N-1): the state is ALARM, and `alarm_latched`=1, `siren`=1, `strobe`=1.
- A single-cycle drop of `alarmEnable` during CONFIRM restarts confirmation from IDLE.
- `silence_btn` sampled high at edge k in ALARM: after edge k, `silenced`=1 and `siren`=0.
  - After edge k+`SILENCE_CYCLES`, the block is back in ALARM or in IDLE.
- TEST entered at edge k returns to IDLE after edge k+`TEST_CYCLES`.
- Siren period in ALARM and TEST is 2×`TONE_HALF` cycles. Strobe period is `STROBE_PERIOD` cycles.

## Configuration
- `ALARM_STROBE_EN`: defined means the strobe counter and `strobe` logic are compiled in, as described above.
- Undefined means `strobe` is tied to 0 and the strobe counter is absent. All other behaviour is identical.

## Test plan
Default parameters unless noted.
- Reset, idle, and test start:
  - Stimulus: hold `rst`=1 for 2 cycles with random inputs, release, keep all inputs at 0 for 20 cycles.
  - Required: all outputs 0.
  - Stimulus: pulse `test_btn` for 1 cycle.
  - Required: `test_active`=1 for exactly 32 cycles and `siren` toggles every 8 cycles.
- Confirmation filter:
  - Stimulus: drive `alarmEnable`=1 for 3 cycles, then 0.
  - Required: `alarm_latched` never rises.
  - Stimulus: drive `alarmEnable`=1 for 4 cycles.
  - Required: `alarm_latched`=1 after the 4th edge; `strobe` pulses every 16 cycles; `alarmEnable` dropping afterward keeps the alarm latched.
- Silence, still burning:
  - Stimulus: in ALARM, pulse `silence_btn` with `alarmEnable`=1.
  - Required: `siren`=0 and `silenced`=1 for 64 cycles, strobe continues; the block then returns to ALARM with `siren`=1.
- Silence, cleared:
  - Stimulus: same as above with `alarmEnable`=0.
  - Required: after 64 cycles all outputs are 0 (IDLE).
  - Stimulus: repeat `silence_btn` presses during the silence window.
  - Required: the silence window does not extend.
- Test abort and reset mid-alarm:
  - Stimulus: in TEST, raise `alarmEnable` for 4 cycles.
  - Required: ALARM is latched on the 4th edge.
  - Stimulus: assert `rst` during SILENCED.
  - Required: all outputs are 0 on the next cycle.
- Macro off:
  - Stimulus: build without `ALARM_STROBE_EN` and rerun the confirmation-filter scenario.
  - Required: `strobe` stays 0; siren timing is unchanged.
